// File: rtl/wave_meter_pkg.sv
// Shared types for the wave_meter receive-side measurement block.
package wave_meter_pkg;

  typedef enum logic [1:0] {UNKNOWN = 2'd0, LOW = 2'd1, HIGH = 2'd2} level_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, MEASURE = 2'd2} state_t;

  localparam int CYCLES_W = 16;

endpackage

// File: rtl/wave_level_detect.sv
// Hysteresis comparator with a level register; flags LOW->HIGH transitions.
module wave_level_detect import wave_meter_pkg::*; #(
  parameter int SAMPLE_W = 16,
  parameter int HYST     = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  output level_t                     level,
  output logic                       rise
);

  localparam logic signed [SAMPLE_W-1:0] TH_HI = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] TH_LO = -TH_HI;

  level_t level_q;

  // level is the level after accepting the current sample, so the
  // accumulators can classify the sample in the same cycle
  always_comb begin
    level = level_q;
    if (sample_valid) begin
      if (sample >= TH_HI)      level = HIGH;
      else if (sample <= TH_LO) level = LOW;
    end
  end

  assign rise = sample_valid && (level_q == LOW) && (level == HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   level_q <= UNKNOWN;
    else if (clr) level_q <= UNKNOWN;
    else          level_q <= level;
  end

endmodule

// File: rtl/wave_meter.sv
// Per-channel period / high-time / amplitude meter on rising zero crossings.
module wave_meter import wave_meter_pkg::*; #(
  parameter int SAMPLE_W   = 16,
  parameter int CNT_W      = 32,
  parameter int HYST       = 256,
  parameter int MAX_PERIOD = 2**20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       meas_valid,
  output logic [CNT_W-1:0]           period,
  output logic [CNT_W-1:0]           high_count,
  output logic signed [SAMPLE_W-1:0] v_max,
  output logic signed [SAMPLE_W-1:0] v_min,
  output logic [CYCLES_W-1:0]        cycles,
  output logic                       timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

  state_t state, state_nxt;
  level_t level;
  logic   rise, acc;
  logic   load, tick, pub, to;

  logic [CNT_W-1:0]           cnt, hi, cnt_inc;
  logic signed [SAMPLE_W-1:0] acc_max, acc_min;

  logic                       pend;
  logic [CNT_W-1:0]           pend_period, pend_hi;
  logic signed [SAMPLE_W-1:0] pend_max, pend_min;

  wave_level_detect #(.SAMPLE_W(SAMPLE_W), .HYST(HYST)) u_lvl (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (!en || state == IDLE),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level),
    .rise         (rise)
  );

  assign acc     = en && sample_valid;
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = SEEK;
        SEEK:    if (acc && rise) state_nxt = MEASURE;
        MEASURE: if (to) state_nxt = SEEK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // rise beats timeout: a rise sample never ticks, so to stays low
  always_comb begin
    load = 1'b0;
    tick = 1'b0;
    pub  = 1'b0;
    to   = 1'b0;
    if (acc) begin
      case (state)
        SEEK:    load = rise;
        MEASURE: begin
          load = rise;
          pub  = rise;
          tick = !rise;
          to   = !rise && (cnt_inc == MAX_CNT);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; hi <= '0; acc_max <= '0; acc_min <= '0;
    end else if (!en) begin
      cnt <= '0; hi <= '0; acc_max <= '0; acc_min <= '0;
    end else if (load) begin
      cnt <= CNT_W'(1); hi <= CNT_W'(1); acc_max <= sample; acc_min <= sample;
    end else if (tick) begin
      cnt <= cnt_inc;
      if (level == HIGH)    hi      <= hi + CNT_W'(1);
      if (sample > acc_max) acc_max <= sample;
      if (sample < acc_min) acc_min <= sample;
    end
  end

  // snapshot at the rise edge; presented one edge later with meas_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; pend_period <= '0; pend_hi <= '0; pend_max <= '0; pend_min <= '0;
    end else if (!en) begin
      pend <= 1'b0; pend_period <= '0; pend_hi <= '0; pend_max <= '0; pend_min <= '0;
    end else begin
      pend <= pub;
      if (pub) begin
        pend_period <= cnt;
        pend_hi     <= hi;
        pend_max    <= acc_max;
        pend_min    <= acc_min;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid <= 1'b0; period <= '0; high_count <= '0;
      v_max <= '0; v_min <= '0; cycles <= '0; timeout <= 1'b0;
    end else if (!en) begin
      meas_valid <= 1'b0; period <= '0; high_count <= '0;
      v_max <= '0; v_min <= '0; cycles <= '0; timeout <= 1'b0;
    end else begin
      meas_valid <= pend;
      if (pend) begin
        period     <= pend_period;
        high_count <= pend_hi;
        v_max      <= pend_max;
        v_min      <= pend_min;
        if (cycles != '1) cycles <= cycles + CYCLES_W'(1);
      end
      if (to)        timeout <= 1'b1;
      else if (pend) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
// Randomised bench for wave_meter against a per-sample reference model.
module tb_wave_meter;

  localparam int SW = 16;
  localparam int CW = 32;
  localparam int HY = 256;
  localparam int MP = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [SW-1:0] sample = '0;
  logic                 meas_valid;
  logic [CW-1:0]        period, high_count;
  logic signed [SW-1:0] v_max, v_min;
  logic [15:0]          cycles;
  logic                 timeout;

  wave_meter #(.SAMPLE_W(SW), .CNT_W(CW), .HYST(HY), .MAX_PERIOD(MP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid), .sample(sample),
    .meas_valid(meas_valid), .period(period), .high_count(high_count),
    .v_max(v_max), .v_min(v_min), .cycles(cycles), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: one entry per sample of the current period
  int  m_lvl;      // 0 unknown, 1 low, 2 high
  bit  m_active, m_measuring, m_pend;
  int  seg_s[$];
  bit  seg_h[$];
  int  p_per, p_hi, p_max, p_min;
  int  e_per, e_hi, e_max, e_min, e_cyc;
  bit  e_mv, e_to;
  int  pubs, phase;

  task automatic model_clear();
    m_lvl = 0; m_active = 0; m_measuring = 0; m_pend = 0;
    seg_s.delete(); seg_h.delete();
    e_per = 0; e_hi = 0; e_max = 0; e_min = 0; e_cyc = 0; e_mv = 0; e_to = 0;
  endtask

  task automatic model_edge(input bit e, input bit v, input int s);
    int nl;
    bit r;
    if (!e) begin model_clear(); return; end
    e_mv = 0;
    if (m_pend) begin
      e_per = p_per; e_hi = p_hi; e_max = p_max; e_min = p_min;
      e_mv = 1; e_to = 0; m_pend = 0;
      if (e_cyc < 65535) e_cyc++;
    end
    if (!m_active) begin m_active = 1; return; end
    if (!v) return;
    nl = (s >= HY) ? 2 : (s <= -HY) ? 1 : m_lvl;
    r = (m_lvl == 1) && (nl == 2);
    m_lvl = nl;
    if (m_measuring && r) begin
      m_pend = 1;
      p_per = seg_s.size(); p_hi = 0; p_max = seg_s[0]; p_min = seg_s[0];
      foreach (seg_s[i]) begin
        if (seg_h[i]) p_hi++;
        if (seg_s[i] > p_max) p_max = seg_s[i];
        if (seg_s[i] < p_min) p_min = seg_s[i];
      end
      seg_s = '{s}; seg_h = '{1'b1};
    end else if (m_measuring) begin
      seg_s.push_back(s); seg_h.push_back(nl == 2);
      if (seg_s.size() == MP) begin m_measuring = 0; e_to = 1; end
    end else if (r) begin
      m_measuring = 1; seg_s = '{s}; seg_h = '{1'b1};
    end
  endtask

  task automatic check_outs();
    chk("meas_valid", meas_valid, e_mv);
    chk("period", period, e_per);
    chk("high_count", high_count, e_hi);
    chk("v_max", v_max, e_max);
    chk("v_min", v_min, e_min);
    chk("cycles", cycles, e_cyc);
    chk("timeout", timeout, e_to);
  endtask

  task automatic step(input bit e, input bit v, input int s);
    en = e; sample_valid = v; sample = SW'(s);
    model_edge(e, v, s);
    @(posedge clk); #1;
    check_outs();
    if (meas_valid) begin
      pubs++;
      if (phase == 2) begin
        chk("sine_period", period, 50);
        chk("sine_vmax_ge_32700", v_max >= 32700, 1);
        chk("sine_vmin_le_m32700", v_min <= -32700, 1);
        chk("sine_hi_24_26", (high_count >= 24) && (high_count <= 26), 1);
      end
      if (phase == 3) chk("noise_period", period, 40);
    end
  endtask

  // mode 0: back-to-back, 1: invalid cycle before every sample, 2: random gaps
  task automatic put(input int s, input int mode);
    if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0))
      step(1, 0, int'($urandom_range(0, 65535)) - 32768);
    step(1, 1, s);
  endtask

  task automatic square(input int nh, input int nl, input int amp, input int noise,
                        input int reps, input int mode);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nh + nl; i++) begin
        int n;
        n = (noise > 0) ? int'($urandom_range(0, 2 * noise)) - noise : 0;
        put(((i < nh) ? amp : -amp) + n, mode);
      end
    end
  endtask

  task automatic restart();
    step(0, 0, 0);
    step(1, 0, 0);
    pubs = 0;
  endtask

  task automatic case1_consts(input string t);
    chk({t, "_pubs"}, pubs, 3);
    chk({t, "_period"}, period, 40);
    chk({t, "_high"}, high_count, 10);
    chk({t, "_vmax"}, v_max, 32767);
    chk({t, "_vmin"}, v_min, -32767);
    chk({t, "_cycles"}, cycles, 3);
  endtask

  initial begin
    model_clear();
    pubs = 0; phase = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    rst_n = 1'b1;

    // square 10 high / 30 low, preceded by lows so four rises occur
    phase = 1;
    restart();
    for (int i = 0; i < 30; i++) put(-32767, 0);
    square(10, 30, 32767, 0, 4, 0);
    step(1, 0, 0);
    case1_consts("sq");

    // one more rise, then DC zero until timeout
    put(32767, 0);
    for (int i = 0; i < 63 + 20; i++) put(0, 0);
    chk("to_flag", timeout, 1);
    chk("to_period_held", period, 40);
    chk("to_cycles", cycles, 4);
    pubs = 0;
    put(-32767, 0); put(32767, 0);
    for (int i = 0; i < 5; i++) put(0, 0);
    chk("to_no_pub_after_seek_rise", pubs, 0);

    // sine, period 50, random phase and random valid gaps
    phase = 2;
    restart();
    begin
      int ph;
      ph = $urandom_range(0, 49);
      for (int i = 0; i < 50 * 6; i++)
        put($rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * (i + ph) / 50.0) + 0.5)), 2);
    end
    step(1, 0, 0);
    chk("sine_pubs", pubs >= 4, 1);

    // +/-1000 square with +/-200 noise
    phase = 3;
    restart();
    for (int i = 0; i < 20; i++) put(-1000 + int'($urandom_range(0, 400)) - 200, 0);
    square(12, 28, 1000, 200, 5, 2);
    step(1, 0, 0);
    chk("noise_pubs", pubs, 4);

    // case-1 stream with sample_valid alternating
    phase = 5;
    restart();
    for (int i = 0; i < 30; i++) put(-32767, 1);
    square(10, 30, 32767, 0, 4, 1);
    step(1, 0, 0);
    case1_consts("alt");

    // async reset mid-period
    phase = 6;
    square(10, 15, 32767, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    pubs = 0;
    for (int i = 0; i < 10; i++) put(-32767, 0);
    square(10, 30, 32767, 0, 1, 0);
    chk("rst_no_pub_one_rise", pubs, 0);
    square(7, 13, 32767, 0, 1, 0);
    step(1, 0, 0);
    chk("rst_pub_after_two_rises", pubs, 1);

    // en low mid-period, then random square stream
    square(10, 5, 32767, 0, 1, 0);
    step(0, 1, 32767);
    step(1, 0, 0);
    for (int k = 0; k < 4; k++)
      square($urandom_range(1, 20), $urandom_range(1, 30), $urandom_range(300, 32767), 0,
             $urandom_range(1, 3), $urandom_range(0, 2));
    step(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
